// File: rtl/spi_reg_target_pkg.sv
// Shared frame geometry and FSM encoding for the SPI register target.
package spi_reg_target_pkg;
  localparam int FRAME_BITS  = 16;
  localparam int CMD_BITS    = 8;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int RW_BIT      = 15;
  localparam int STATUS_ADDR = 0;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    COMMIT
  } state_e;
endpackage

// File: rtl/spi_reg_target_edge_sync.sv
// Two-flop synchronizer with registered rise/fall detection on the synchronized value.
module spi_edge_sync (
  input  logic clk,
  input  logic RST_N,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);
  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_async};
      prev_q <= sync_q[1];
      o_rise <= sync_q[1] & ~prev_q;
      o_fall <= ~sync_q[1] & prev_q;
    end
  end

  // prev_q is the sample the edge flags were computed from, so data and edge stay aligned.
  assign o_sync = prev_q;
endmodule

// File: rtl/spi_reg_target.sv
// 3-wire SPI mode-0 target decoding 16-bit frames into reads/writes of an 8-bit register file.
module spi_reg_target
  import spi_reg_target_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       RST_N,
  input  logic                       i_sclk,
  input  logic                       i_mosi,
  output logic                       o_miso,
  input  logic [DATA_W-1:0]          i_status,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic                       o_wr_strobe,
  output logic [ADDR_W-1:0]          o_wr_addr,
  output logic [DATA_W-1:0]          o_wr_data,
  output logic                       o_busy,
  output logic                       o_frame_err,
  output state_e                     o_dbg_state
);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_edge_sync u_sclk_sync (
    .clk    (clk),
    .RST_N  (RST_N),
    .i_async(i_sclk),
    .o_sync (sclk_sync),
    .o_rise (sclk_rise),
    .o_fall (sclk_fall)
  );

  spi_edge_sync u_mosi_sync (
    .clk    (clk),
    .RST_N  (RST_N),
    .i_async(i_mosi),
    .o_sync (mosi_sync),
    .o_rise (mosi_rise),
    .o_fall (mosi_fall)
  );

  assign unused_sync = ^{sclk_sync, mosi_rise, mosi_fall};

  state_e                 state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [IDLE_W-1:0]      idle_cnt_q;
  logic [FRAME_BITS-2:0]  shift_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      tx_q;
  logic [DATA_W-1:0]      regs_q [1:NUM_REGS-1];

  logic [FRAME_BITS-1:0]  shift_next;
  logic [ADDR_W-1:0]      cmd_addr;
  logic [DATA_W-1:0]      rd_byte;
  logic                   wr_ok;

  // shift_next is the frame including the bit arriving on this rise.
  assign shift_next = {shift_q, mosi_sync};
  assign cmd_addr   = shift_next[ADDR_W-1:0];
  assign wr_ok      = !shift_next[RW_BIT] && (addr_q != ADDR_W'(STATUS_ADDR))
                      && (int'(addr_q) < NUM_REGS);

  always_comb begin
    rd_byte = '0;
    if (cmd_addr == ADDR_W'(STATUS_ADDR)) rd_byte = i_status;
    for (int k = 1; k < NUM_REGS; k++) begin
      if (cmd_addr == ADDR_W'(k)) rd_byte = regs_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      tx_q        <= '0;
      o_miso      <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
      for (int k = 1; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      o_wr_strobe <= 1'b0;
      o_frame_err <= 1'b0;
      if (sclk_rise) shift_q <= shift_next[FRAME_BITS-2:0];
      case (state_q)
        IDLE: begin
          o_miso     <= 1'b0;
          idle_cnt_q <= '0;
          if (sclk_rise) begin
            state_q   <= CMD;
            o_busy    <= 1'b1;
            bit_cnt_q <= CNT_W'(1);
          end
        end
        CMD, DATA: begin
          // Any edge restarts the idle window and outranks a same-cycle timeout.
          if (sclk_rise || sclk_fall) begin
            idle_cnt_q <= '0;
          end else if (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1)) begin
            state_q     <= IDLE;
            o_busy      <= 1'b0;
            bit_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            o_miso      <= 1'b0;
            o_frame_err <= 1'b1;
          end else begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
          if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (state_q == CMD && bit_cnt_q == CNT_W'(CMD_BITS - 1)) begin
              addr_q  <= cmd_addr;
              tx_q    <= shift_next[CMD_BITS-1] ? rd_byte : '0;
              state_q <= DATA;
            end
            if (state_q == DATA && bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
              state_q <= COMMIT;
              if (wr_ok) begin
                for (int k = 1; k < NUM_REGS; k++) begin
                  if (addr_q == ADDR_W'(k)) regs_q[k] <= shift_next[DATA_W-1:0];
                end
                o_wr_addr   <= addr_q;
                o_wr_data   <= shift_next[DATA_W-1:0];
                o_wr_strobe <= 1'b1;
              end
            end
          end
          if (sclk_fall && state_q == DATA) begin
            o_miso <= tx_q[DATA_W-1];
            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
          end
        end
        COMMIT: begin
          o_miso     <= 1'b0;
          idle_cnt_q <= '0;
          if (sclk_rise) begin
            state_q   <= CMD;
            bit_cnt_q <= CNT_W'(1);
          end else begin
            state_q   <= IDLE;
            o_busy    <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_regs = '0;
    for (int k = 1; k < NUM_REGS; k++) o_regs[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_spi_reg_target.sv
// Self-checking bench: drives SPI frames as a mode-0 master and checks against a register-file model.
module tb_spi_reg_target;
  import spi_reg_target_pkg::*;

  localparam int NUM_REGS     = 8;
  localparam int IDLE_TIMEOUT = 64;

  logic                  clk;
  logic                  RST_N;
  logic                  i_sclk;
  logic                  i_mosi;
  logic                  o_miso;
  logic [7:0]            i_status;
  logic [NUM_REGS*8-1:0] o_regs;
  logic                  o_wr_strobe;
  logic [6:0]            o_wr_addr;
  logic [7:0]            o_wr_data;
  logic                  o_busy;
  logic                  o_frame_err;
  state_e                o_dbg_state;

  spi_reg_target #(
    .NUM_REGS    (NUM_REGS),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk        (clk),
    .RST_N      (RST_N),
    .i_sclk     (i_sclk),
    .i_mosi     (i_mosi),
    .o_miso     (o_miso),
    .i_status   (i_status),
    .o_regs     (o_regs),
    .o_wr_strobe(o_wr_strobe),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  int          err_seen = 0;
  bit          run_cmp  = 1'b0;
  bit          miso_window = 1'b0;
  int          read_tail_until = -1;
  logic [14:0] exp_q[$];
  logic [7:0]  model_regs [NUM_REGS];
  logic [7:0]  img [NUM_REGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] img_word();
    logic [63:0] w;
    w = '0;
    for (int k = 0; k < NUM_REGS; k++) w[k*8 +: 8] = img[k];
    return w;
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [14:0] e;
    for (int k = 0; k < NUM_REGS; k++) img[k] = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (run_cmp) begin
        if (!RST_N) begin
          for (int k = 0; k < NUM_REGS; k++) img[k] = 8'h00;
        end
        if (o_wr_strobe) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 64'(o_wr_strobe), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("strobe_addr", 64'(o_wr_addr), 64'(e[14:8]));
            check("strobe_data", 64'(o_wr_data), 64'(e[7:0]));
            img[int'(e[14:8])] = e[7:0];
          end
        end
        check("regs_image", o_regs, img_word());
        if (!(miso_window || cyc <= read_tail_until))
          check("miso_quiet", 64'(o_miso), 64'd0);
        if (o_frame_err) err_seen++;
      end
    end
  end

  // ---------------- driver ----------------
  // Call on a negedge with sclk low; sclk high/low phases are 4 clk each.
  task automatic send_frame(input logic [15:0] frame, input int nbits, input bit check_tail,
                            output logic [7:0] got);
    logic       is_read;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    bit         wr_valid;
    is_read  = frame[15];
    addr     = frame[14:8];
    data     = frame[7:0];
    got      = 8'h00;
    wr_valid = (nbits == 16) && !is_read && (addr != 7'd0) && (int'(addr) < NUM_REGS);
    if (addr == 7'd0) exp_rd = i_status;
    else if (int'(addr) < NUM_REGS) exp_rd = model_regs[int'(addr)];
    else exp_rd = 8'h00;
    if (wr_valid) begin
      exp_q.push_back({addr, data});
      model_regs[int'(addr)] = data;
    end
    for (int i = 0; i < nbits; i++) begin
      i_mosi = frame[15-i];
      if (is_read && i >= 8) miso_window = 1'b1;
      repeat (4) @(negedge clk);
      if (i >= 8) got = {got[6:0], o_miso};
      i_sclk = 1'b1;
      if (check_tail && i == nbits - 1) begin
        repeat (4) @(posedge clk);
        #1;
        check("tail_strobe", 64'(o_wr_strobe), 64'(wr_valid));
        check("tail_busy_commit", 64'(o_busy), 64'd1);
        @(posedge clk);
        #1;
        check("tail_busy_idle", 64'(o_busy), 64'd0);
        check("tail_strobe_drop", 64'(o_wr_strobe), 64'd0);
        @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
      i_sclk = 1'b0;
    end
    i_mosi = 1'b0;
    if (is_read && nbits == 16) begin
      read_tail_until = cyc + 6;
      check("rd_data", 64'(got), 64'(exp_rd));
    end
    miso_window = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] got;
    logic [6:0] ra;
    logic       rr;
    logic [7:0] rd;
    int         e0;
    RST_N    = 1'b0;
    i_sclk   = 1'b0;
    i_mosi   = 1'b0;
    i_status = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", 64'(o_miso), 64'd0);
    check("rst_regs", o_regs, 64'd0);
    check("rst_strobe", 64'(o_wr_strobe), 64'd0);
    check("rst_wr_addr", 64'(o_wr_addr), 64'd0);
    check("rst_wr_data", 64'(o_wr_data), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_frame_err", 64'(o_frame_err), 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'(IDLE));
    @(negedge clk);
    RST_N   = 1'b1;
    run_cmp = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(16'h02A5, 16, 1'b1, got);
    check("w02_addr", 64'(o_wr_addr), 64'd2);
    check("w02_data", 64'(o_wr_data), 64'hA5);
    check("w02_reg2", 64'(o_regs[23:16]), 64'hA5);
    send_frame(16'h8200, 16, 1'b0, got);
    check("r02_lit", 64'(got), 64'hA5);

    i_status = 8'h3C;
    send_frame(16'h8000, 16, 1'b0, got);
    check("r00_status_lit", 64'(got), 64'h3C);
    send_frame(16'h0011, 16, 1'b1, got);
    check("w00_regs_lit", o_regs, 64'h0000_0000_00A5_0000);

    send_frame(16'h7F55, 16, 1'b1, got);
    send_frame(16'hFF00, 16, 1'b0, got);
    check("r7f_lit", 64'(got), 64'h00);

    e0 = err_seen;
    send_frame(16'h0123, 5, 1'b0, got);
    repeat (IDLE_TIMEOUT + 6) @(negedge clk);
    check("timeout_busy", 64'(o_busy), 64'd0);
    check("timeout_err_pulses", 64'(err_seen - e0), 64'd1);
    send_frame(16'h0377, 16, 1'b0, got);
    check("w03_reg3_lit", 64'(o_regs[31:24]), 64'h77);

    send_frame(16'h04EE, 10, 1'b0, got);
    RST_N = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) model_regs[k] = 8'h00;
    @(posedge clk);
    #1;
    check("midrst_regs", o_regs, 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_strobe", 64'(o_wr_strobe), 64'd0);
    check("midrst_wr_addr", 64'(o_wr_addr), 64'd0);
    check("midrst_wr_data", 64'(o_wr_data), 64'd0);
    check("midrst_miso", 64'(o_miso), 64'd0);
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    repeat (2) @(negedge clk);

    send_frame(16'h0501, 16, 1'b0, got);
    send_frame(16'h0602, 16, 1'b0, got);
    repeat (4) @(negedge clk);
    check("b2b_reg5_lit", 64'(o_regs[47:40]), 64'h01);
    check("b2b_reg6_lit", 64'(o_regs[55:48]), 64'h02);
    check("b2b_reg4_lit", 64'(o_regs[39:32]), 64'h00);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 7) == 0) ra = 7'($urandom_range(NUM_REGS, 127));
      else ra = 7'($urandom_range(0, NUM_REGS - 1));
      rr       = 1'($urandom_range(0, 1));
      rd       = 8'($urandom);
      i_status = 8'($urandom);
      send_frame({rr, ra, rd}, 16, 1'b0, got);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    run_cmp = 1'b0;
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    check("frame_err_total", 64'(err_seen), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
